rv32i_decode_queue: RTL and testbench

//  Buffered decode stage between fetch and execute. Accepts raw {pc, inst} words, holds them in a

---
 rtl/rv32i_pkg.sv | 81 ++++++++
 rtl/rv32i_decoder.sv | 129 ++++++++++++
 rtl/rv32i_decode_queue.sv | 103 ++++++++++
 tb/tb_rv32i_decode_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: instruction view, decoded bundle, enums and the immediate generator.
package rv32i_pkg;

    // Decoded pc field is fixed width; narrower queue PCs are zero-extended into it.
    localparam int DEC_PC_W = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_s;

    typedef union packed {
        logic [31:0] raw;
        r_type_s     r;
    } rv32i_inst_u;

    typedef enum logic [2:0] {OPTYPE_R, OPTYPE_I, OPTYPE_S, OPTYPE_B, OPTYPE_U, OPTYPE_J} optype_e;

    typedef enum logic [4:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_op_e;

    typedef enum logic [1:0] {ALU_INPUT1_RS1, ALU_INPUT1_PC, ALU_INPUT1_NONE} alu_input1_type_e;
    typedef enum logic [1:0] {ALU_INPUT2_RS2, ALU_INPUT2_IMM, ALU_INPUT2_NONE} alu_input2_type_e;
    typedef enum logic [2:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC, WB_CSR} wb_from_e;
    typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_op_e;
    typedef enum logic [1:0] {BRANCH_NONE, BRANCH_RELATIVE, BRANCH_ABSOLUTE} branch_type_e;
    // Encoded so that funct3[1:0] of a CSR instruction casts directly.
    typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} csr_op_e;
    typedef enum logic [0:0] {CSR_ALU_INPUT_RS1, CSR_ALU_INPUT_IMM} csr_alu_input_type_e;

    typedef struct packed {
        logic [DEC_PC_W-1:0] pc;
        alu_op_e             alu_op;
        alu_input1_type_e    alu_in1;
        alu_input2_type_e    alu_in2;
        logic [31:0]         imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                reg_we;
        wb_from_e            wb_from;
        logic                mem_en;
        mem_op_e             mem_op;
        logic [2:0]          funct3;
        branch_type_e        branch_type;
        csr_op_e             csr_op;
        csr_alu_input_type_e csr_alu_input;
        logic [11:0]         csr_addr;
        logic                illegal;
    } dec_inst_s;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input optype_e t);
        case (t)
            OPTYPE_I: imm_gen = {{20{i[31]}}, i[31:20]};
            OPTYPE_S: imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
            OPTYPE_B: imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OPTYPE_U: imm_gen = {i[31:12], 12'b0};
            OPTYPE_J: imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:  imm_gen = 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Pure combinational RV32I decoder: instruction word + pc -> dec_inst_s bundle.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  rv32i_inst_u         inst,
    input  logic [DEC_PC_W-1:0] pc,
    output dec_inst_s           dec
);

    logic [2:0] f3;
    logic       alt;

    assign f3  = inst.r.funct3;
    assign alt = inst.r.funct7[5];

    always_comb begin
        dec             = '0;
        dec.pc          = pc;
        dec.alu_op      = ALU_NOP;
        dec.alu_in1     = ALU_INPUT1_RS1;
        dec.alu_in2     = ALU_INPUT2_RS2;
        dec.rs1         = inst.r.rs1;
        dec.rs2         = inst.r.rs2;
        dec.rd          = inst.r.rd;
        dec.funct3      = f3;
        dec.wb_from     = WB_NONE;
        dec.mem_op      = MEM_NONE;
        dec.branch_type = BRANCH_NONE;
        dec.csr_op      = CSR_NONE;
        dec.csr_alu_input = CSR_ALU_INPUT_RS1;
        dec.imm         = imm_gen(inst.raw, OPTYPE_I);
        dec.csr_addr    = inst.raw[31:20];
        dec.illegal     = 1'b0;

        case (inst.r.opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec.alu_op  = ALU_ADD;
                dec.alu_in1 = (inst.r.opcode == OPC_LUI) ? ALU_INPUT1_NONE : ALU_INPUT1_PC;
                dec.alu_in2 = ALU_INPUT2_IMM;
                dec.imm     = imm_gen(inst.raw, OPTYPE_U);
                dec.wb_from = WB_ALU;
            end
            OPC_JAL: begin
                dec.alu_op      = ALU_ADD;
                dec.alu_in1     = ALU_INPUT1_PC;
                dec.alu_in2     = ALU_INPUT2_IMM;
                dec.imm         = imm_gen(inst.raw, OPTYPE_J);
                dec.wb_from     = WB_PC;
                dec.branch_type = BRANCH_RELATIVE;
            end
            OPC_JALR: begin
                dec.alu_op      = ALU_ADD;
                dec.alu_in2     = ALU_INPUT2_IMM;
                dec.wb_from     = WB_PC;
                dec.branch_type = BRANCH_ABSOLUTE;
            end
            OPC_BRANCH: begin
                dec.imm         = imm_gen(inst.raw, OPTYPE_B);
                dec.branch_type = BRANCH_RELATIVE;
                case (f3)
                    3'b000:  dec.alu_op = ALU_BEQ;
                    3'b001:  dec.alu_op = ALU_BNE;
                    3'b100:  dec.alu_op = ALU_BLT;
                    3'b101:  dec.alu_op = ALU_BGE;
                    3'b110:  dec.alu_op = ALU_BLTU;
                    3'b111:  dec.alu_op = ALU_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.alu_op  = ALU_ADD;
                dec.alu_in2 = ALU_INPUT2_IMM;
                dec.mem_en  = 1'b1;
                dec.mem_op  = MEM_LOAD;
                dec.wb_from = WB_MEM;
                dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.alu_op  = ALU_ADD;
                dec.alu_in2 = ALU_INPUT2_IMM;
                dec.imm     = imm_gen(inst.raw, OPTYPE_S);
                dec.mem_en  = 1'b1;
                dec.mem_op  = MEM_STORE;
                dec.illegal = (f3 > 3'b010);
            end
            OPC_OPIMM, OPC_OP: begin
                dec.wb_from = WB_ALU;
                if (inst.r.opcode == OPC_OPIMM) begin
                    dec.alu_in2 = ALU_INPUT2_IMM;
                end else begin
                    dec.imm     = 32'b0;
                    dec.illegal = !((inst.r.funct7 == 7'b0000000) ||
                                    (inst.r.funct7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                end
                case (f3)
                    // Immediate bit 10 of ADDI is not an opcode modifier, so SUB only exists on OP.
                    3'b000:  dec.alu_op = (alt && inst.r.opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
                    3'b001:  dec.alu_op = ALU_SLL;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101:  dec.alu_op = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_FENCE: dec.alu_op = ALU_NOP;
            OPC_SYSTEM: begin
                if (f3 != 3'b000) begin
                    dec.csr_op        = csr_op_e'(f3[1:0]);
                    dec.wb_from       = WB_CSR;
                    dec.csr_alu_input = f3[2] ? CSR_ALU_INPUT_IMM : CSR_ALU_INPUT_RS1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase

        if (dec.illegal) begin
            dec.alu_op      = ALU_NOP;
            dec.wb_from     = WB_NONE;
            dec.mem_en      = 1'b0;
            dec.mem_op      = MEM_NONE;
            dec.branch_type = BRANCH_NONE;
            dec.csr_op      = CSR_NONE;
        end
        dec.reg_we = !dec.illegal && (dec.rd != 5'd0) && (dec.wb_from != WB_NONE);
    end

endmodule

// File: rtl/rv32i_decode_queue.sv
// Buffered RV32I decode stage: DEPTH-entry FIFO, registered decoded output, flush on redirect.
// Optional perf counters (perf_dec, perf_ill) when RV32I_DECODE_PERF_CNT_EN is defined.
module rv32i_decode_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
`ifdef RV32I_DECODE_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  rv32i_inst_u         in_inst,
    output logic                out_valid,
    input  logic                out_ready,
    output dec_inst_s           out_dec
`ifdef RV32I_DECODE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_dec,
    output logic [CNT_WIDTH-1:0] perf_ill
`endif
);

    // Handshake: a transfer happens on a cycle where valid && ready at the rising edge;
    // valid never depends combinationally on ready, and in_ready depends only on count.
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    rv32i_inst_u         mem_inst [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic                push, pop;
    logic [DEC_PC_W-1:0] head_pc;
    dec_inst_s           head_dec;

    assign in_ready = (count < FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && (!out_valid || out_ready);
    assign head_pc  = DEC_PC_W'(mem_pc[rd_ptr]);

    rv32i_decoder u_decoder (
        .inst (mem_inst[rd_ptr]),
        .pc   (head_pc),
        .dec  (head_dec)
    );

    // Storage needs no reset; a dropped push is harmless since wr_ptr does not advance.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= in_inst;
            mem_pc[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_dec   <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                out_dec   <= head_dec;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RV32I_DECODE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_dec <= '0;
            perf_ill <= '0;
        end else if (out_valid && out_ready) begin
            perf_dec <= perf_dec + CNT_WIDTH'(1);
            if (out_dec.illegal) perf_ill <= perf_ill + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_decode_queue.sv
// Directed bench for rv32i_decode_queue with hand-computed decode results and a pc scoreboard.
module tb_rv32i_decode_queue;
    import rv32i_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    dec_inst_s   out_dec;
`ifdef RV32I_DECODE_PERF_CNT_EN
    logic [31:0] perf_dec, perf_ill;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    rv32i_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec)
`ifdef RV32I_DECODE_PERF_CNT_EN
        ,
        .perf_dec  (perf_dec),
        .perf_ill  (perf_ill)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Push one word into an empty queue with out_ready high and capture the emitted bundle.
    task automatic run_one(input logic [31:0] inst, input logic [31:0] pc, output dec_inst_s d);
        bit seen;
        seen = 1'b0;
        d = '0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (out_valid) begin
                d = out_dec;
                seen = 1'b1;
            end
            tick();
        end
        check_eq("run_one_seen", 64'(seen), 64'd1);
    endtask

    dec_inst_s d;
    int        accepted, got_n, first_i, last_i, seen_n;

    initial begin
        // Reset
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_dec_nonzero", 64'(out_dec != '0), 64'd0);

        // 1: ADDI x1,x0,5 latency and decode
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h100;
        tick();
        in_valid = 1'b0;
        check_eq("addi_not_yet", 64'(out_valid), 64'd0);
        tick();
        check_eq("addi_valid", 64'(out_valid), 64'd1);
        check_eq("addi_alu", 64'(out_dec.alu_op), 64'(ALU_ADD));
        check_eq("addi_imm", 64'(out_dec.imm), 64'd5);
        check_eq("addi_rd", 64'(out_dec.rd), 64'd1);
        check_eq("addi_we", 64'(out_dec.reg_we), 64'd1);
        check_eq("addi_in2", 64'(out_dec.alu_in2), 64'(ALU_INPUT2_IMM));
        check_eq("addi_pc", 64'(out_dec.pc), 64'h100);
        tick();
        check_eq("addi_consumed", 64'(out_valid), 64'd0);

        // 2: fill with back-pressure, then drain in order at full rate
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 10 && in_ready; i++) begin
            in_valid = 1'b1;
            in_inst  = 32'h0000_0013;
            in_pc    = 32'h200 + 32'(4 * i);
            exp_q.push_back(in_pc);
            accepted++;
            tick();
        end
        in_valid = 1'b0;
        check_eq("fill_accepted", 64'(accepted), 64'(DEPTH + 1));
        check_eq("fill_in_ready", 64'(in_ready), 64'd0);
        tick();
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_pc", 64'(out_dec.pc), 64'(exp_q[0]));
        out_ready = 1'b1;
        got_n = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                if (first_i < 0) first_i = i;
                last_i = i;
                got_n++;
                if (exp_q.size() != 0) check_eq("drain_pc", 64'(out_dec.pc), 64'(exp_q.pop_front()));
                else check_eq("drain_extra", 64'(out_dec.pc), 64'hFFFF_FFFF);
            end
            tick();
        end
        check_eq("drain_count", 64'(got_n), 64'(DEPTH + 1));
        check_eq("drain_rate", 64'(last_i - first_i), 64'(DEPTH));
        check_eq("drain_q_empty", 64'(exp_q.size()), 64'd0);

        // 3: BEQ x0,x0,-4
        run_one(32'hFE00_0EE3, 32'h300, d);
        check_eq("beq_alu", 64'(d.alu_op), 64'(ALU_BEQ));
        check_eq("beq_imm", 64'(d.imm), 64'hFFFF_FFFC);
        check_eq("beq_we", 64'(d.reg_we), 64'd0);
        check_eq("beq_branch", 64'(d.branch_type), 64'(BRANCH_RELATIVE));

        // 4: flush with three buffered entries and a simultaneous push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = 32'h0000_0013;
            in_pc    = 32'h400 + 32'(4 * i);
            tick();
        end
        check_eq("pre_flush_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1; in_pc = 32'hDEAD0; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen_n++;
            tick();
        end
        check_eq("flush_nothing_left", 64'(seen_n), 64'd0);
        run_one(32'h0050_0093, 32'h500, d);
        check_eq("post_flush_pc", 64'(d.pc), 64'h500);

        // 5: illegal word, then LUI x0
        run_one(32'hFFFF_FFFF, 32'h600, d);
        check_eq("ill_flag", 64'(d.illegal), 64'd1);
        check_eq("ill_alu", 64'(d.alu_op), 64'(ALU_NOP));
        check_eq("ill_wb", 64'(d.wb_from), 64'(WB_NONE));
        run_one(32'h1234_5037, 32'h604, d);
        check_eq("lui_ill", 64'(d.illegal), 64'd0);
        check_eq("lui_we", 64'(d.reg_we), 64'd0);
        check_eq("lui_imm", 64'(d.imm), 64'h1234_5000);
        check_eq("lui_in1", 64'(d.alu_in1), 64'(ALU_INPUT1_NONE));

        // Further opcode classes
        run_one(32'h4020_81B3, 32'h700, d);
        check_eq("sub_alu", 64'(d.alu_op), 64'(ALU_SUB));
        check_eq("sub_we", 64'(d.reg_we), 64'd1);
        run_one(32'h8020_81B3, 32'h704, d);
        check_eq("op_bad_f7", 64'(d.illegal), 64'd1);
        run_one(32'h0081_2283, 32'h708, d);
        check_eq("lw_mem_op", 64'(d.mem_op), 64'(MEM_LOAD));
        check_eq("lw_wb", 64'(d.wb_from), 64'(WB_MEM));
        check_eq("lw_imm", 64'(d.imm), 64'd8);
        run_one(32'hFE61_2C23, 32'h70C, d);
        check_eq("sw_imm", 64'(d.imm), 64'hFFFF_FFF8);
        check_eq("sw_mem_op", 64'(d.mem_op), 64'(MEM_STORE));
        check_eq("sw_we", 64'(d.reg_we), 64'd0);
        run_one(32'h0002_80E7, 32'h710, d);
        check_eq("jalr_wb", 64'(d.wb_from), 64'(WB_PC));
        check_eq("jalr_branch", 64'(d.branch_type), 64'(BRANCH_ABSOLUTE));
        run_one(32'h3002_D3F3, 32'h714, d);
        check_eq("csr_op", 64'(d.csr_op), 64'(CSR_RW));
        check_eq("csr_in", 64'(d.csr_alu_input), 64'(CSR_ALU_INPUT_IMM));
        check_eq("csr_addr", 64'(d.csr_addr), 64'h300);
        check_eq("csr_wb", 64'(d.wb_from), 64'(WB_CSR));
        run_one(32'h0000_1217, 32'h718, d);
        check_eq("auipc_in1", 64'(d.alu_in1), 64'(ALU_INPUT1_PC));
        check_eq("auipc_imm", 64'(d.imm), 64'h1000);
        run_one(32'hFE00_2EE3, 32'h71C, d);
        check_eq("br_bad_f3", 64'(d.illegal), 64'd1);
        check_eq("br_bad_f3_branch", 64'(d.branch_type), 64'(BRANCH_NONE));

`ifdef RV32I_DECODE_PERF_CNT_EN
        // 6: perf counters over 10 consumed bundles, 2 illegal
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("perf_rst", 64'(perf_dec), 64'd0);
        for (int i = 0; i < 10; i++) begin
            run_one((i == 3 || i == 7) ? 32'hFFFF_FFFF : 32'h0050_0093, 32'(i), d);
        end
        check_eq("perf_dec", 64'(perf_dec), 64'd10);
        check_eq("perf_ill", 64'(perf_ill), 64'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("perf_dec_flush", 64'(perf_dec), 64'd10);
        check_eq("perf_ill_flush", 64'(perf_ill), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
